// File: rtl/clk_ce_pkg.sv
// Shared types and constants for the fractional clock-enable generator.
// The supervisor FSM states and the DSP clock ratio constants live here.
package clk_ce_pkg;

    typedef enum logic [1:0] {
        ST_WAIT = 2'd0,
        ST_HOLD = 2'd1,
        ST_RUN  = 2'd2
    } sup_state_t;

    localparam int unsigned ACC_W_DEF      = 20;
    localparam int unsigned LOCK_HOLD_DEF  = 1024;
    localparam int unsigned LOCK_CNT_W_DEF = $clog2(LOCK_HOLD_DEF);

    // The PLL gives 24.46875 MHz instead of the nominal 24.576 MHz.
    localparam int unsigned CLK_ACT_HZ = 24_468_750;
    localparam int unsigned CLK_NOM_HZ = 24_576_000;

    // 24.46875 MHz * 128 / 97875 = 32 kHz exactly
    localparam logic [ACC_W_DEF-1:0] NUM_32K = 20'd128;
    localparam logic [ACC_W_DEF-1:0] DEN_32K = 20'd97875;

    // nominal/actual clock ratio, reduced
    localparam logic [ACC_W_DEF-1:0] NUM_NOM_ACT = 20'd32768;
    localparam logic [ACC_W_DEF-1:0] DEN_NOM_ACT = 20'd32625;

endpackage

// File: rtl/clk_ce_chan.sv
// One fractional clock-enable channel: num/den/acc registers, the
// compare-subtract step and the registered ce output.
module clk_ce_chan
    import clk_ce_pkg::*;
#(
    parameter int unsigned      ACC_W   = ACC_W_DEF,
    parameter logic [ACC_W-1:0] NUM_RST = '0,
    parameter logic [ACC_W-1:0] DEN_RST = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             run,
    input  logic             clr,
    input  logic             wr,
    input  logic [ACC_W-1:0] wr_num,
    input  logic [ACC_W-1:0] wr_den,
    output logic             ce
);

    logic [ACC_W-1:0] num;
    logic [ACC_W-1:0] den;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] num_eff;
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W:0]   sum;
    logic             hit;

    // num is clipped to den, so an over-range ratio simply fires every cycle
    always_comb begin
        num_eff = (num > den) ? den : num;
        sum     = {1'b0, acc} + {1'b0, num_eff};
        hit     = (den != '0) && (sum >= {1'b0, den});
        acc_nxt = hit ? ACC_W'(sum - {1'b0, den}) : sum[ACC_W-1:0];
    end

    // a config write beats lock-loss clear and accumulation on the same edge
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            num <= NUM_RST;
            den <= DEN_RST;
            acc <= '0;
            ce  <= 1'b0;
        end else if (wr) begin
            num <= wr_num;
            den <= wr_den;
            acc <= '0;
            ce  <= 1'b0;
        end else if (clr) begin
            acc <= '0;
            ce  <= 1'b0;
        end else if (run && (den != '0)) begin
            acc <= acc_nxt;
            ce  <= hit;
        end else begin
            ce  <= 1'b0;
        end
    end

endmodule

// File: rtl/clk_ce_gen.sv
// PLL lock supervisor with debounced reset release, feeding NCH fractional
// clock-enable channels whose rate is exactly clk * num / den.
module clk_ce_gen
    import clk_ce_pkg::*;
#(
    parameter int unsigned              NCH       = 2,
    parameter int unsigned              ACC_W     = ACC_W_DEF,
    parameter int unsigned              LOCK_HOLD = LOCK_HOLD_DEF,
    parameter logic [NCH*ACC_W-1:0]     NUM_INIT  = '0,
    parameter logic [NCH*ACC_W-1:0]     DEN_INIT  = '0
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             pll_lock,
    input  logic             cfg_we,
    input  logic [2:0]       cfg_ch,
    input  logic [ACC_W-1:0] cfg_num,
    input  logic [ACC_W-1:0] cfg_den,
    output logic             ready,
    output logic             rst_out_n,
    output logic [NCH-1:0]   ce,
    output logic [7:0]       lock_lost
);

    localparam int unsigned LOCK_CNT_W = $clog2(LOCK_HOLD);

    sup_state_t            state;
    sup_state_t            state_nxt;
    logic                  lock_m;
    logic                  lock_s;
    logic [LOCK_CNT_W-1:0] hold_cnt;
    logic                  hold_done;
    logic                  hold_run;
    logic                  run_acc;
    logic                  lost_evt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_m <= 1'b0;
            lock_s <= 1'b0;
        end else begin
            lock_m <= pll_lock;
            lock_s <= lock_m;
        end
    end

    assign hold_done = (hold_cnt == LOCK_CNT_W'(LOCK_HOLD - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= ST_WAIT;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_WAIT: if (lock_s) state_nxt = ST_HOLD;
            ST_HOLD: begin
                if (!lock_s) begin
                    state_nxt = ST_WAIT;
                end else if (hold_done) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN:  if (!lock_s) state_nxt = ST_WAIT;
            default: state_nxt = ST_WAIT;
        endcase
    end

    // gating on lock_s makes ce drop on the same edge ready falls
    always_comb begin
        hold_run = 1'b0;
        run_acc  = 1'b0;
        lost_evt = 1'b0;
        case (state)
            ST_HOLD: hold_run = lock_s;
            ST_RUN: begin
                run_acc  = lock_s;
                lost_evt = !lock_s;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            hold_cnt <= '0;
        end else if (hold_run) begin
            hold_cnt <= hold_cnt + 1'b1;
        end else begin
            hold_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ready     <= 1'b0;
            rst_out_n <= 1'b0;
            lock_lost <= '0;
        end else begin
            ready     <= (state_nxt == ST_RUN);
            rst_out_n <= (state_nxt == ST_RUN);
            if (lost_evt && (lock_lost != 8'hFF)) begin
                lock_lost <= lock_lost + 8'd1;
            end
        end
    end

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        logic wr_sel;

        assign wr_sel = cfg_we && (cfg_ch == 3'(i));

        clk_ce_chan #(
            .ACC_W   (ACC_W),
            .NUM_RST (NUM_INIT[i*ACC_W +: ACC_W]),
            .DEN_RST (DEN_INIT[i*ACC_W +: ACC_W])
        ) u_chan (
            .clk    (clk),
            .resetn (resetn),
            .run    (run_acc),
            .clr    (lost_evt),
            .wr     (wr_sel),
            .wr_num (cfg_num),
            .wr_den (cfg_den),
            .ce     (ce[i])
        );
    end

endmodule

// File: tb/tb_clk_ce_gen.sv
// Directed bench for clk_ce_gen: lock bring-up, exact-rate pulses, edge
// ratios, config collisions, lock loss and asynchronous reset.
module tb_clk_ce_gen;
    import clk_ce_pkg::*;

    localparam int unsigned NCH       = 2;
    localparam int unsigned ACC_W     = 20;
    localparam int unsigned LOCK_HOLD = 16;
    localparam logic [NCH*ACC_W-1:0] NUM_INIT = {20'd128,   20'd1};
    localparam logic [NCH*ACC_W-1:0] DEN_INIT = {20'd97875, 20'd4};

    logic             clk = 1'b0;
    logic             resetn;
    logic             pll_lock;
    logic             cfg_we;
    logic [2:0]       cfg_ch;
    logic [ACC_W-1:0] cfg_num;
    logic [ACC_W-1:0] cfg_den;
    logic             ready;
    logic             rst_out_n;
    logic [NCH-1:0]   ce;
    logic [7:0]       lock_lost;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    clk_ce_gen #(
        .NCH       (NCH),
        .ACC_W     (ACC_W),
        .LOCK_HOLD (LOCK_HOLD),
        .NUM_INIT  (NUM_INIT),
        .DEN_INIT  (DEN_INIT)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .pll_lock  (pll_lock),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_num   (cfg_num),
        .cfg_den   (cfg_den),
        .ready     (ready),
        .rst_out_n (rst_out_n),
        .ce        (ce),
        .lock_lost (lock_lost)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_v(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic check(input logic [31:0] act);
        exp_t e;
        vectors++;
        if (sb_q.size() == 0) begin
            miscompares++;
            $error("FAIL scoreboard_empty: observed %0h, no expected entry", act);
        end else begin
            e = sb_q.pop_front();
            assert (act === e.val) else begin
                miscompares++;
                $error("FAIL %s: observed %0h expected %0h", e.tag, act, e.val);
            end
        end
    endtask

    task automatic exp_chk(input string tag, input logic [31:0] v, input logic [31:0] act);
        expect_v(tag, v);
        check(act);
    endtask

    task automatic cfg_write(input logic [2:0] ch, input logic [ACC_W-1:0] n,
                             input logic [ACC_W-1:0] d);
        cfg_we  = 1'b1;
        cfg_ch  = ch;
        cfg_num = n;
        cfg_den = d;
        tick();
        cfg_we  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed timeout, expected bench completion");
        $fatal(1, "bench timed out");
    end

    initial begin
        int  cnt0;
        int  cnt1;
        int  n_run;
        longint exp_k;

        resetn   = 1'b0;
        pll_lock = 1'b0;
        cfg_we   = 1'b0;
        cfg_ch   = '0;
        cfg_num  = '0;
        cfg_den  = '0;

        // reset state
        repeat (3) tick();
        exp_chk("rst_ready", 0, ready);
        exp_chk("rst_rst_out_n", 0, rst_out_n);
        exp_chk("rst_ce", 0, ce);
        exp_chk("rst_lock_lost", 0, lock_lost);
        resetn = 1'b1;
        tick();

        // bring-up: ready 19 cycles after pll_lock rises
        pll_lock = 1'b1;
        repeat (18) tick();
        exp_chk("bringup_ready_e18", 0, ready);
        tick();
        exp_chk("bringup_ready_e19", 1, ready);
        exp_chk("bringup_rst_out_n", 1, rst_out_n);

        // exact rate: ch0 1/4, ch1 128/97875 from reset values
        for (int k = 0; k <= 12; k++) expect_v("ch0_rate_1_4", 32'((k > 0) && (k % 4 == 0)));
        cnt0  = 0;
        cnt1  = 0;
        n_run = 20000;
        for (int k = 0; k <= n_run; k++) begin
            if (k != 0) tick();
            if (k <= 12) check(32'(ce[0]));
            if (k >= 1 && ce[0]) cnt0++;
            if (ce[1]) begin
                cnt1++;
                exp_k = (longint'(cnt1) * 97875 + 127) / 128;
                exp_chk("ch1_pulse_cycle", 32'(exp_k), 32'(k));
            end
        end
        exp_chk("ch0_count", 32'(n_run / 4), 32'(cnt0));
        exp_chk("ch1_count", 26, 32'(cnt1));

        // num = den: write cycle silent, then every cycle
        expect_v("ratio_5_5", 0);
        repeat (4) expect_v("ratio_5_5", 1);
        cfg_write(3'd0, 20'd5, 20'd5);
        check(32'(ce[0]));
        repeat (4) begin tick(); check(32'(ce[0])); end

        // num > den behaves as num = den
        expect_v("ratio_7_5", 0);
        repeat (4) expect_v("ratio_7_5", 1);
        cfg_write(3'd0, 20'd7, 20'd5);
        check(32'(ce[0]));
        repeat (4) begin tick(); check(32'(ce[0])); end

        // den = 0 disables the channel
        repeat (8) expect_v("den_zero", 0);
        cfg_write(3'd0, 20'd3, 20'd0);
        check(32'(ce[0]));
        repeat (7) begin tick(); check(32'(ce[0])); end

        // collision: rewrite on the edge where 1/4 would fire
        repeat (4) expect_v("coll_pre", 0);
        cfg_write(3'd0, 20'd1, 20'd4);
        check(32'(ce[0]));
        repeat (3) begin tick(); check(32'(ce[0])); end
        expect_v("coll_write_edge", 0);
        expect_v("coll_post", 0);
        expect_v("coll_post", 0);
        expect_v("coll_post", 1);
        cfg_write(3'd0, 20'd1, 20'd3);
        check(32'(ce[0]));
        repeat (3) begin tick(); check(32'(ce[0])); end

        // out-of-range channel index must not touch ch0
        expect_v("bad_ch", 0);
        expect_v("bad_ch", 0);
        expect_v("bad_ch", 1);
        cfg_write(3'd2, 20'd1, 20'd1);
        check(32'(ce[0]));
        repeat (2) begin tick(); check(32'(ce[0])); end

        // lock loss from RUN with ch0 firing every cycle
        cfg_write(3'd0, 20'd5, 20'd5);
        tick();
        pll_lock = 1'b0;
        tick();
        exp_chk("loss_e1_ready", 1, ready);
        exp_chk("loss_e1_ce0", 1, ce[0]);
        tick();
        exp_chk("loss_e2_ready", 1, ready);
        exp_chk("loss_e2_ce0", 1, ce[0]);
        tick();
        exp_chk("loss_e3_ready", 0, ready);
        exp_chk("loss_e3_rst_out_n", 0, rst_out_n);
        exp_chk("loss_e3_ce", 0, ce);
        exp_chk("loss_e3_lock_lost", 1, lock_lost);

        // one-cycle glitch in HOLD restarts the hold count
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        tick();
        pll_lock = 1'b1;
        repeat (13) tick();
        exp_chk("glitch_ready_e19", 0, ready);
        repeat (5) tick();
        exp_chk("glitch_ready_e24", 0, ready);
        tick();
        exp_chk("glitch_ready_e25", 1, ready);
        exp_chk("glitch_lost_unchanged", 1, lock_lost);
        exp_chk("relock_ce0_c0", 0, ce[0]);
        tick();
        exp_chk("relock_ce0_c1", 1, ce[0]);

        // lock_lost saturates at 255
        for (int i = 2; i <= 300; i++) begin
            pll_lock = 1'b0;
            repeat (3) tick();
            if (i == 254) exp_chk("lost_254", 254, lock_lost);
            if (i == 255) exp_chk("lost_255", 255, lock_lost);
            pll_lock = 1'b1;
            repeat (19) tick();
        end
        exp_chk("lost_sat", 255, lock_lost);
        exp_chk("lost_sat_ready", 1, ready);
        tick();
        exp_chk("pre_reset_ce0", 1, ce[0]);

        // asynchronous reset between clock edges
        #3;
        resetn = 1'b0;
        #1;
        exp_chk("areset_ready", 0, ready);
        exp_chk("areset_rst_out_n", 0, rst_out_n);
        exp_chk("areset_ce", 0, ce);
        exp_chk("areset_lock_lost", 0, lock_lost);
        repeat (2) tick();
        resetn = 1'b1;
        repeat (19) tick();
        exp_chk("rerun_ready", 1, ready);
        // ch0 back to its reset ratio 1/4
        for (int k = 0; k <= 4; k++) expect_v("rerun_ce0_init", 32'(k == 4));
        for (int k = 0; k <= 4; k++) begin
            if (k != 0) tick();
            check(32'(ce[0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
